// File: rtl/poci_master_bridge.sv
// Bridges a single-outstanding core request/response port onto a POCI segment (SETUP -> ACCESS with wait states).
// Optional ACCESS watchdog: define POCI_TIMEOUT_EN to force an error completion after TIMEOUT wait cycles.
module poci_master_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

`ifdef POCI_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state and next-output decode for the transfer sequencer
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef POCI_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef POCI_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end
            ST_ACCESS: begin
                // Read data is returned only for clean reads; writes and errors report zero
                if (pready) begin
                    state_d      = ST_IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = pslverr;
                    resp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                end
`ifdef POCI_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d      = ST_IDLE;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                end
`else
                else begin
                    state_d      = ST_ACCESS;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef POCI_TIMEOUT_EN
            wait_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef POCI_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_poci_master_bridge.sv
// Bench for poci_master_bridge: transaction-level timeline model, per-cycle compare, directed and random transfers.
module tb_poci_master_bridge;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXC = 4000;
`ifdef POCI_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int WMAX = 6;
`else
    localparam int TO   = 255;
    localparam int WMAX = 4;
`endif

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          req_ready, resp_valid, resp_err, psel, penable, pwrite;
    logic [DW-1:0] resp_rdata, pwdata;
    logic [AW-1:0] paddr;

    poci_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit in_reset = 1'b1;

    // Expected outputs per cycle index, and slave-side stimulus plan per cycle
    logic          exp_ready[MAXC], exp_psel[MAXC], exp_pen[MAXC], exp_pwrite[MAXC];
    logic          exp_rv[MAXC], exp_err[MAXC];
    logic [AW-1:0] exp_paddr[MAXC];
    logic [DW-1:0] exp_pwdata[MAXC], exp_rdata[MAXC];
    logic          plan_pready[MAXC], plan_pslverr[MAXC];
    logic [DW-1:0] plan_prdata[MAXC];
    int            idle_from = 0;
    logic          last_err = 1'b0;
    logic [DW-1:0] last_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_ready[c] = 1'b1; exp_psel[c] = 1'b0; exp_pen[c] = 1'b0; exp_pwrite[c] = 1'b0;
            exp_rv[c] = 1'b0; exp_err[c] = 1'b0; exp_paddr[c] = '0; exp_pwdata[c] = '0;
            exp_rdata[c] = '0;
        end
        last_err = 1'b0; last_rdata = '0; idle_from = from;
    endtask

    // Transfer accepted at cycle t; slave holds pready low for w ACCESS cycles, then completes with e/rd
    task automatic schedule(input int t, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int w, input logic e, input logic [DW-1:0] rd);
        logic          to_s;
        int            alen, rc;
        logic          nerr;
        logic [DW-1:0] nrd;
`ifdef POCI_TIMEOUT_EN
        to_s = (w >= TO);
`else
        to_s = 1'b0;
`endif
        alen = to_s ? TO : w + 1;
        rc   = t + 2 + alen;
        nerr = to_s | e;
        nrd  = (to_s || wr || e) ? '0 : rd;
        for (int c = t + 1; c < MAXC; c++) begin
            exp_paddr[c] = a; exp_pwrite[c] = wr; exp_pwdata[c] = d;
            exp_ready[c] = (c >= rc);
            exp_psel[c]  = (c < rc);
            exp_pen[c]   = (c >= t + 2) && (c < rc);
            exp_rv[c]    = (c == rc);
            exp_err[c]   = (c >= rc) ? nerr : last_err;
            exp_rdata[c] = (c >= rc) ? nrd : last_rdata;
        end
        for (int c = t + 2; c < rc && c < MAXC; c++) begin
            plan_pready[c] = (c == t + 2 + w);
            if (c == t + 2 + w) begin
                plan_prdata[c]  = rd;
                plan_pslverr[c] = e;
            end
        end
        last_err = nerr; last_rdata = nrd; idle_from = rc;
    endtask

    task automatic raise(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    endtask

    task automatic wait_accept(input int w, input logic e, input logic [DW-1:0] rd, output int t);
        while (cyc < idle_from) begin
            @(posedge pclk); #2;
        end
        t = cyc;
        schedule(t, req_write, req_addr, req_wdata, w, e, rd);
        @(posedge pclk); #2;
        req_valid = 1'b0;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge pclk); #2;
        end
    endtask

    // Slave model: drives the planned pready/prdata/pslverr for each cycle
    initial begin
        forever begin
            @(posedge pclk); #2;
            if (cyc < MAXC) begin
                pready  = plan_pready[cyc];
                prdata  = plan_prdata[cyc];
                pslverr = plan_pslverr[cyc];
            end
        end
    end

    // Per-cycle compare of every DUT output against the timeline model
    always @(negedge pclk) begin
        if (!in_reset && cyc < MAXC) begin
            chk("req_ready", req_ready, exp_ready[cyc]);
            chk("psel", psel, exp_psel[cyc]);
            chk("penable", penable, exp_pen[cyc]);
            chk("pwrite", pwrite, exp_pwrite[cyc]);
            chk("paddr", paddr, exp_paddr[cyc]);
            chk("pwdata", pwdata, exp_pwdata[cyc]);
            chk("resp_valid", resp_valid, exp_rv[cyc]);
            chk("resp_err", resp_err, exp_err[cyc]);
            chk("resp_rdata", resp_rdata, exp_rdata[cyc]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, pen_cnt;
        for (int c = 0; c < MAXC; c++) begin
            plan_pready[c]  = 1'($urandom);
            plan_pslverr[c] = 1'($urandom);
            plan_prdata[c]  = $urandom;
        end
        model_reset(0);
        repeat (3) @(posedge pclk);
        #2;
        preset = 1'b0;
        model_reset(cyc);
        in_reset = 1'b0;
        chk("rst_psel", psel, 64'd0);
        chk("rst_penable", penable, 64'd0);
        chk("rst_resp_valid", resp_valid, 64'd0);
        chk("rst_paddr", paddr, 64'd0);
        chk("rst_req_ready", req_ready, 64'd1);

        // Zero-wait write
        raise(1'b1, 12'h004, 32'h0000_00A5);
        wait_accept(0, 1'b0, 32'h1111_2222, t);
        at_cycle(t + 1); chk("zw_psel_t1", psel, 64'd1); chk("zw_pen_t1", penable, 64'd0);
        at_cycle(t + 2); chk("zw_pen_t2", penable, 64'd1); chk("zw_pwdata", pwdata, 64'hA5);
        at_cycle(t + 3); chk("zw_rv_t3", resp_valid, 64'd1);
        chk("zw_err", resp_err, 64'd0); chk("zw_rdata", resp_rdata, 64'd0);

        // Read with three wait states
        raise(1'b0, 12'h008, 32'h0);
        wait_accept(3, 1'b0, 32'h0000_03FF, t);
        for (int c = 1; c <= 5; c++) begin
            at_cycle(t + c); chk("rd3_paddr", paddr, 64'h008);
        end
        at_cycle(t + 6); chk("rd3_rv_t6", resp_valid, 64'd1); chk("rd3_rdata", resp_rdata, 64'h3FF);

        // Slave error on a read
        raise(1'b0, 12'h00C, 32'h0);
        wait_accept(0, 1'b1, 32'hDEAD_BEEF, t);
        at_cycle(t + 3); chk("err_rv", resp_valid, 64'd1);
        chk("err_flag", resp_err, 64'd1); chk("err_rdata", resp_rdata, 64'd0);

        // Back-to-back: second request held while the first is in flight
        raise(1'b1, 12'h010, 32'h1234_5678);
        wait_accept(1, 1'b0, 32'h0, t1);
        raise(1'b0, 12'h014, 32'h0);
        at_cycle(t1 + 4);
        chk("b2b_rv", resp_valid, 64'd1); chk("b2b_ready", req_ready, 64'd1); chk("b2b_gap_psel", psel, 64'd0);
        wait_accept(0, 1'b0, 32'h0000_5A5A, t2);
        at_cycle(t2 + 1); chk("b2b_psel2", psel, 64'd1); chk("b2b_paddr2", paddr, 64'h014);
        at_cycle(t2 + 3); chk("b2b_rdata2", resp_rdata, 64'h5A5A);

        // Reset while in ACCESS
        raise(1'b0, 12'h020, 32'h0);
        wait_accept(5, 1'b0, 32'hCAFE_0001, t);
        at_cycle(t + 3); chk("rst_mid_pen_before", penable, 64'd1);
        #1; preset = 1'b1; in_reset = 1'b1;
        #1; chk("rst_mid_psel", psel, 64'd0); chk("rst_mid_pen", penable, 64'd0);
        repeat (2) @(posedge pclk);
        #2;
        preset = 1'b0;
        model_reset(cyc);
        in_reset = 1'b0;
        chk("rst_mid_ready", req_ready, 64'd1); chk("rst_mid_rv", resp_valid, 64'd0);

        // Slave never ready
        raise(1'b0, 12'h030, 32'h0);
        wait_accept(1000, 1'b0, 32'h0000_0077, t);
`ifdef POCI_TIMEOUT_EN
        pen_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            at_cycle(t + c);
            if (penable) pen_cnt++;
            if (c == 6) begin
                chk("to_rv", resp_valid, 64'd1); chk("to_err", resp_err, 64'd1); chk("to_rdata", resp_rdata, 64'd0);
            end
        end
        chk("to_access_cycles", pen_cnt, 64'd4);
`else
        pen_cnt = 0;
        at_cycle(t + 1002);
        chk("stuck_pen", penable, 64'd1); chk("stuck_psel", psel, 64'd1); chk("stuck_rv", resp_valid, 64'd0);
`endif

        // Random traffic, including held back-to-back requests
        for (int i = 0; i < 120; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                req_valid = 1'b0;
                repeat (gap) begin
                    req_addr = 12'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
                    @(posedge pclk); #2;
                end
            end
            raise(1'($urandom), 12'($urandom), $urandom);
            wait_accept($urandom_range(0, WMAX), ($urandom_range(0, 5) == 0), $urandom, t);
        end
        at_cycle(idle_from + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/poci_master_bridge.md
Name: poci_master_bridge

Overview:
- Upstream stage of the POCI peripheral slaves (LEDs, switches, timers).
- Converts the core's single-outstanding request/response port into POCI transfers (SETUP → ACCESS, with wait states).
- Captures the slave's read data and error status and returns them as a one-cycle response pulse.
- One instance per POCI segment; peripherals hang off its bus outputs.

Parameters:
- ADDR_WIDTH, 12, width of req_addr and paddr (peripheral decoders use paddr[11:0]).
- DATA_WIDTH, 32, width of wdata/rdata on both sides.
- TIMEOUT, 255, max ACCESS cycles before forced error; used only with POCI_TIMEOUT_EN; legal range 1..255.

Ports:
- pclk  in  1  clock, rising edge
- preset  in  1  asynchronous reset, active-high
- req_valid  in  1  core request present
- req_ready  out  1  bridge can accept request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  read data, 0 for writes/errors
- resp_err  out  1  transfer ended with pslverr or timeout
- psel  out  1  POCI select
- penable  out  1  POCI enable (ACCESS phase)
- pwrite  out  1  POCI direction
- paddr  out  ADDR_WIDTH  POCI address
- pwdata  out  DATA_WIDTH  POCI write data
- prdata  in  DATA_WIDTH  slave read data, valid when psel&penable&pready&~pwrite
- pready  in  1  slave ready, sampled only in ACCESS
- pslverr  in  1  slave error, sampled only with pready in ACCESS

Behaviour:
- Single clock pclk; reset asynchronous, active-high (preset). All outputs registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, resp_valid=0, resp_rdata=0, resp_err=0. State=IDLE, so req_ready=1 once preset deasserts.
- req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- FSM states:
  - IDLE: on req_valid&req_ready, register req_write/req_addr/req_wdata into pwrite/paddr/pwdata. Next cycle: psel=1, penable=0, state=SETUP.
  - SETUP: lasts exactly one cycle. Next cycle: penable=1, state=ACCESS.
  - ACCESS: psel=penable=1; paddr/pwrite/pwdata held stable. If pready=0, stay (wait state). If pready=1, go to IDLE. In that transition:
    - psel=0, penable=0.
    - resp_valid=1 for exactly one cycle.
    - resp_err=pslverr.
    - resp_rdata = prdata if (~pwrite & ~pslverr), else 0.
- resp_rdata/resp_err hold their value after resp_valid falls, until the next response.
- paddr/pwrite/pwdata keep their last value in IDLE; they change only on request acceptance.
- Zero-wait latency: accept at cycle T, SETUP at T+1, ACCESS with pready at T+2, resp_valid at T+3. Each wait state adds 1 cycle.
- Back-to-back: the cycle with resp_valid=1 is IDLE with req_ready=1. A request accepted there enters SETUP next cycle, giving one idle bus cycle (psel=0) between transfers.
- req_valid while not ready: the core holds the request; the bridge ignores it.
- prdata/pslverr are ignored outside ACCESS&pready.
- Reset mid-transfer, any state: return immediately to reset values; no response is generated; the aborted transfer is lost.

Optional Feature:
- Macro: POCI_TIMEOUT_EN.
- Defined: 8-bit counter cleared on SETUP→ACCESS, incremented each ACCESS cycle with pready=0. If count==TIMEOUT-1 and pready=0, terminate exactly as a pready=1 completion, but with resp_err=1 and resp_rdata=0. A simultaneous pready=1 on that cycle wins: normal completion.
- Not defined: no counter; ACCESS waits indefinitely for pready; TIMEOUT is unused.

Test Plan:
- Zero-wait write: req addr=0x004, wdata=0x000000A5, pready=1 → psel at T+1, penable at T+2; resp_valid at T+3 with resp_err=0, resp_rdata=0.
- Read with 3 wait states: addr=0x008, pready low 3 ACCESS cycles, prdata=0x000003FF → paddr stable throughout; resp_valid at T+6, resp_rdata=0x3FF.
- Slave error: read with pslverr=1, pready=1, prdata=0xDEADBEEF → resp_err=1, resp_rdata=0.
- Back-to-back: second req_valid held during first transfer → accepted in resp_valid cycle; exactly one psel=0 cycle between transfers.
- Reset in ACCESS: assert preset while penable=1 → psel/penable=0 asynchronously; no resp_valid; req_ready=1 after release.
- POCI_TIMEOUT_EN with TIMEOUT=4, pready stuck 0 → exactly 4 ACCESS cycles; resp_valid with resp_err=1. Without the macro, still in ACCESS after 1000 cycles.
